instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
Inverse of the main control decoder. It accepts instruction descriptions (operation class plus register and immediate fields) over a valid/ready handshake, encodes each into a 32-bit RV32I word, and writes the words sequentially into instruction memory. It is used to preload programs for bring-up and verification of the single-cycle core. It supports exactly the classes the core decodes: lw, sw, R-type, I-type ALU and beq.

Parameters:
ADDR_W, 32, width of instruction-memory byte address.
BASE_ADDR, 0, byte address of the first written word; must be 4-byte aligned.
DEPTH, 64, maximum words per load session; must be at least 1.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset.
Start  in  1  single-cycle pulse that begins a load session.
In_Valid  in  1  instruction description valid.
In_Ready  out  1  block can accept a description.
In_Last  in  1  marks the final description of the session.
Op_Class  in  3  0=lw, 1=sw, 2=R, 3=I-ALU, 4=beq; 5-7 illegal.
Funct3  in  3  used for R and I only; lw/sw force 010, beq forces 000.
Funct7b5  in  1  R only; funct7 = {0,Funct7b5,00000}.
Rd  in  5  destination register (lw/R/I).
Rs1  in  5  source 1.
Rs2  in  5  source 2 (sw/R/beq).
Imm  in  13  lw/sw/I use Imm[11:0]; beq uses Imm[12:1], and Imm[0] is ignored.
IMem_WE  out  1  instruction-memory write strobe.
IMem_Addr  out  ADDR_W  byte address of the word being written.
IMem_WData  out  32  encoded word.
Count  out  $clog2(DEPTH+1)  words written in the current session.
Done  out  1  session finished; level signal.
Full  out  1  session ended because DEPTH was reached.
Err  out  1  sticky; an illegal Op_Class was received.

Behaviour:
- Reset is synchronous and active-low: RST=0 sampled at a CLK rising edge resets the block; clock is CLK only.
- Reset values:
  - state=IDLE.
  - In_Ready, IMem_WE, IMem_WData, Count, Done, Full and Err are all 0.
  - The internal address and IMem_Addr are BASE_ADDR.
- FSM IDLE:
  - In_Ready=0.
  - Start moves to LOAD, clears Count/Err/Full, and sets the address to BASE_ADDR.
- FSM LOAD:
  - In_Ready=1; a transfer occurs on a cycle with In_Valid&In_Ready.
  - A legal transfer registers the encoded word and moves to WRITE.
  - An illegal transfer sets Err, writes nothing, and does not advance the address. It then goes to DONE if In_Last=1, otherwise stays in LOAD.
- FSM WRITE (exactly one cycle):
  - In_Ready=0 and IMem_WE=1; IMem_Addr and IMem_WData are stable.
  - At the end of the cycle, address += 4 and Count += 1.
  - Next state is DONE (with Full=1) if the new Count equals DEPTH. Otherwise it is DONE if the captured Last was 1, else LOAD.
- FSM DONE:
  - Done=1 and In_Ready=0.
  - Start restarts the session exactly as from IDLE.
- Start is ignored in LOAD and WRITE.
- Latency: accept at edge k gives IMem_WE=1 during cycle k+1. Maximum throughput is one word per 2 cycles.
- IMem_WE is 1 only in WRITE, never in any other state.
- Encoding:
  - lw = Imm[11:0],Rs1,010,Rd,0000011.
  - sw = Imm[11:5],Rs2,Rs1,010,Imm[4:0],0100011.
  - R = funct7,Rs2,Rs1,Funct3,Rd,0110011.
  - I = Imm[11:0],Rs1,Funct3,Rd,0010011.
  - beq = Imm[12],Imm[10:5],Rs2,Rs1,000,Imm[4:1],Imm[11],1100011.
- Address wraps modulo 2^ADDR_W with no error; within DEPTH this does not occur for sane BASE_ADDR.
- If In_Valid is held while In_Ready=0, no transfer occurs; the source must hold its fields until the transfer.
- Reset mid-session: on the next edge the block is in IDLE with reset values. A write in progress is dropped after that edge, with no partial write.

Test Plan:
- Reset, Start, then one transfer {lw, Rd=5, Rs1=2, Imm=8, Last=1} -> one WE pulse, Addr=0x0, WData=0x00812283, then Count=1, Done=1.
- Stream sw{Rs2=6,Rs1=2,Imm=4} then R{Funct3=0,Funct7b5=1,Rd=7,Rs1=5,Rs2=6,Last} -> WData 0x00612223 at 0x0, then 0x406283B3 at 0x4; Count=2.
- beq{Rs1=5,Rs2=6,Imm=13'h1FFC,Last} -> WData=0xFE628EE3; Imm[0]=1 gives the same word.
- Op_Class=6 mid-stream between two legal words -> Err=1, no WE for it, and the legal words land at consecutive addresses 0x0 and 0x4.
- DEPTH=2 with 3 valid descriptions and no Last -> 2 writes, Full=1, Done=1, In_Ready=0, and the third description is never accepted.
- RST low during WRITE -> WE=0 from the next cycle, all outputs at reset values, and Start succeeds afterwards with Addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Encodes lw/sw/R/I-ALU/beq descriptions into RV32I words and writes them sequentially into instruction memory.
// Latency: a description accepted at edge k drives IMem_WE during cycle k+1; at most one word every 2 cycles.
// Backpressure: In_Ready is high only in LOAD; the source holds In_Valid and its fields until a transfer.
module instr_encode_loader #(
  parameter int          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int          DEPTH     = 64,
  localparam int         CW        = $clog2(DEPTH+1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              In_Last,
  input  logic [2:0]        Op_Class,
  input  logic [2:0]        Funct3,
  input  logic              Funct7b5,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [12:0]       Imm,
  output logic              IMem_WE,
  output logic [ADDR_W-1:0] IMem_Addr,
  output logic [31:0]       IMem_WData,
  output logic [CW-1:0]     Count,
  output logic              Done,
  output logic              Full,
  output logic              Err
);

  // Operation classes as presented on Op_Class
  localparam logic [2:0] CLS_LW  = 3'd0;
  localparam logic [2:0] CLS_SW  = 3'd1;
  localparam logic [2:0] CLS_R   = 3'd2;
  localparam logic [2:0] CLS_I   = 3'd3;
  localparam logic [2:0] CLS_BEQ = 3'd4;

  // Major opcodes of the supported instruction classes
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic            last_q;
  logic [31:0]     enc_word;
  logic            enc_legal;
  logic [CW-1:0]   count_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  // Branch offsets are always even, so Imm[0] carries no information
  logic unused_imm0;
  assign unused_imm0 = Imm[0];

  assign count_nxt = Count + CW'(1);
  assign addr_nxt  = IMem_Addr + ADDR_W'(4);

  // Combinational encoder: maps the current description to its RV32I word
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (Op_Class)
      CLS_LW:  enc_word = {Imm[11:0], Rs1, 3'b010, Rd, OPC_LW};
      CLS_SW:  enc_word = {Imm[11:5], Rs2, Rs1, 3'b010, Imm[4:0], OPC_SW};
      CLS_R:   enc_word = {1'b0, Funct7b5, 5'b00000, Rs2, Rs1, Funct3, Rd, OPC_R};
      CLS_I:   enc_word = {Imm[11:0], Rs1, Funct3, Rd, OPC_I};
      CLS_BEQ: enc_word = {Imm[12], Imm[10:5], Rs2, Rs1, 3'b000, Imm[4:1], Imm[11], OPC_BEQ};
      default: enc_legal = 1'b0;
    endcase
  end

  // Session FSM; every output is a register updated alongside the state
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      last_q     <= 1'b0;
      In_Ready   <= 1'b0;
      IMem_WE    <= 1'b0;
      IMem_Addr  <= BASE_ADDR;
      IMem_WData <= 32'h0;
      Count      <= '0;
      Done       <= 1'b0;
      Full       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state     <= LOAD;
            In_Ready  <= 1'b1;
            Done      <= 1'b0;
            Full      <= 1'b0;
            Err       <= 1'b0;
            Count     <= '0;
            IMem_Addr <= BASE_ADDR;
          end
        end
        LOAD: begin
          if (In_Valid) begin
            if (enc_legal) begin
              state      <= WRITE;
              IMem_WData <= enc_word;
              last_q     <= In_Last;
              In_Ready   <= 1'b0;
              IMem_WE    <= 1'b1;
            end else begin
              // Illegal class: flag it, drop it, keep the address where it is
              Err <= 1'b1;
              if (In_Last) begin
                state    <= DONE;
                In_Ready <= 1'b0;
                Done     <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          IMem_WE   <= 1'b0;
          IMem_Addr <= addr_nxt;
          Count     <= count_nxt;
          if (count_nxt == CW'(DEPTH)) begin
            state <= DONE;
            Full  <= 1'b1;
            Done  <= 1'b1;
          end else if (last_q) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            state    <= LOAD;
            In_Ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encodings, streaming, illegal classes, DEPTH limit, reset mid-write.
// Latency: checks the accept-edge -> WE-next-cycle timing explicitly.
// Backpressure: descriptions are held until In_Ready is seen high.
module tb_instr_encode_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic        Start2 = 1'b0;
  logic        In_Valid = 1'b0;
  logic        In_Valid2 = 1'b0;
  logic        In_Last = 1'b0;
  logic [2:0]  Op_Class = 3'd0;
  logic [2:0]  Funct3 = 3'd0;
  logic        Funct7b5 = 1'b0;
  logic [4:0]  Rd = 5'd0;
  logic [4:0]  Rs1 = 5'd0;
  logic [4:0]  Rs2 = 5'd0;
  logic [12:0] Imm = 13'd0;

  logic        In_Ready, IMem_WE, Done, Full, Err;
  logic [31:0] IMem_Addr, IMem_WData;
  logic [6:0]  Count;

  logic        In_Ready2, IMem_WE2, Done2, Full2, Err2;
  logic [31:0] IMem_Addr2, IMem_WData2;
  logic [1:0]  Count2;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] wr2_addr[$];

  instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(64)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Last(In_Last), .Op_Class(Op_Class), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm), .IMem_WE(IMem_WE), .IMem_Addr(IMem_Addr),
    .IMem_WData(IMem_WData), .Count(Count), .Done(Done), .Full(Full), .Err(Err)
  );

  instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .Start(Start2), .In_Valid(In_Valid2), .In_Ready(In_Ready2),
    .In_Last(In_Last), .Op_Class(Op_Class), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm), .IMem_WE(IMem_WE2), .IMem_Addr(IMem_Addr2),
    .IMem_WData(IMem_WData2), .Count(Count2), .Done(Done2), .Full(Full2), .Err(Err2)
  );

  always #5 CLK = ~CLK;

  // Write log, sampled mid-cycle so it sees each WE cycle exactly once
  always @(negedge CLK) begin
    if (IMem_WE) begin
      wr_addr.push_back(IMem_Addr);
      wr_data.push_back(IMem_WData);
    end
    if (IMem_WE2) wr2_addr.push_back(IMem_Addr2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic set_desc(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [12:0] imm, input logic last);
    Op_Class = cls; Funct3 = f3; Funct7b5 = f7;
    Rd = rd; Rs1 = rs1; Rs2 = rs2; Imm = imm; In_Last = last;
  endtask

  // Holds In_Valid until In_Ready is seen, then lets the accept edge pass
  task automatic send(input string tag);
    int budget;
    budget = 20;
    In_Valid = 1'b1;
    while (!In_Ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!In_Ready) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for In_Ready", tag);
    end
    tick();
    In_Valid = 1'b0;
  endtask

  initial begin
    // Reset
    RST = 1'b0;
    tick(); tick();
    check("rst_ready", {31'd0, In_Ready}, 32'd0);
    check("rst_we",    {31'd0, IMem_WE}, 32'd0);
    check("rst_addr",  IMem_Addr, 32'h0);
    check("rst_wdata", IMem_WData, 32'h0);
    check("rst_count", {25'd0, Count}, 32'd0);
    check("rst_flags", {29'd0, Done, Full, Err}, 32'd0);
    RST = 1'b1;
    tick();
    check("idle_ready", {31'd0, In_Ready}, 32'd0);

    // Single lw
    pulse_start();
    check("load_ready", {31'd0, In_Ready}, 32'd1);
    set_desc(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1);
    send("lw");
    check("lw_we",    {31'd0, IMem_WE}, 32'd1);
    check("lw_ready", {31'd0, In_Ready}, 32'd0);
    check("lw_addr",  IMem_Addr, 32'h0);
    check("lw_wdata", IMem_WData, 32'h00812283);
    tick();
    check("lw_we_off", {31'd0, IMem_WE}, 32'd0);
    check("lw_count",  {25'd0, Count}, 32'd1);
    check("lw_done",   {29'd0, Done, Full, Err}, 32'b100);
    check("lw_addr_nxt", IMem_Addr, 32'h4);
    tick();
    check("done_ready", {31'd0, In_Ready}, 32'd0);

    // sw then R, streamed
    pulse_start();
    check("restart_addr", IMem_Addr, 32'h0);
    check("restart_done", {31'd0, Done}, 32'd0);
    set_desc(3'd1, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 13'd4, 1'b0);
    send("sw");
    check("sw_addr",  IMem_Addr, 32'h0);
    check("sw_wdata", IMem_WData, 32'h00612223);
    tick();
    check("sw_ready_again", {31'd0, In_Ready}, 32'd1);
    check("sw_notdone", {31'd0, Done}, 32'd0);
    set_desc(3'd2, 3'd0, 1'b1, 5'd7, 5'd5, 5'd6, 13'd0, 1'b1);
    send("r");
    check("r_addr",  IMem_Addr, 32'h4);
    check("r_wdata", IMem_WData, 32'h406283B3);
    tick();
    check("r_count", {25'd0, Count}, 32'd2);
    check("r_done",  {31'd0, Done}, 32'd1);

    // beq, with Imm[0] both clear and set
    pulse_start();
    set_desc(3'd4, 3'd5, 1'b1, 5'd9, 5'd5, 5'd6, 13'h1FFC, 1'b1);
    send("beq");
    check("beq_wdata", IMem_WData, 32'hFE628EE3);
    tick();
    pulse_start();
    set_desc(3'd4, 3'd5, 1'b1, 5'd9, 5'd5, 5'd6, 13'h1FFD, 1'b1);
    send("beq_imm0");
    check("beq_imm0_wdata", IMem_WData, 32'hFE628EE3);
    tick();

    // I-ALU, illegal class, then lw: legal words at consecutive addresses
    pulse_start();
    wr_addr.delete();
    wr_data.delete();
    set_desc(3'd3, 3'd7, 1'b0, 5'd3, 5'd4, 5'd0, 13'h0FFF, 1'b0);
    send("iop");
    check("iop_wdata", IMem_WData, 32'hFFF27193);
    tick();
    set_desc(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
    send("illegal");
    check("illegal_err",   {31'd0, Err}, 32'd1);
    check("illegal_no_we", {31'd0, IMem_WE}, 32'd0);
    check("illegal_ready", {31'd0, In_Ready}, 32'd1);
    check("illegal_addr",  IMem_Addr, 32'h4);
    set_desc(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1);
    send("lw2");
    tick();
    check("mix_nwrites", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check("mix_addr0", wr_addr[0], 32'h0);
      check("mix_addr1", wr_addr[1], 32'h4);
      check("mix_data0", wr_data[0], 32'hFFF27193);
      check("mix_data1", wr_data[1], 32'h00812283);
    end
    check("mix_count", {25'd0, Count}, 32'd2);
    check("mix_flags", {29'd0, Done, Full, Err}, 32'b101);

    // Illegal class as the last description; Start clears Err
    pulse_start();
    check("start_clr_err", {31'd0, Err}, 32'd0);
    wr_addr.delete();
    set_desc(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0, 1'b1);
    send("illegal_last");
    check("illegal_last_flags", {29'd0, Done, Full, Err}, 32'b101);
    check("illegal_last_count", {25'd0, Count}, 32'd0);
    tick();
    check("illegal_last_nowr", wr_addr.size(), 32'd0);

    // DEPTH=2 instance: three valid descriptions, no Last
    set_desc(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 13'd0, 1'b0);
    Start2 = 1'b1;
    tick();
    Start2 = 1'b0;
    In_Valid2 = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("full_nwrites", wr2_addr.size(), 32'd2);
    if (wr2_addr.size() == 2) check("full_addr1", wr2_addr[1], 32'h4);
    check("full_flags", {29'd0, Done2, Full2, Err2}, 32'b110);
    check("full_ready", {31'd0, In_Ready2}, 32'd0);
    check("full_count", {30'd0, Count2}, 32'd2);
    In_Valid2 = 1'b0;

    // Reset during WRITE
    pulse_start();
    wr_addr.delete();
    set_desc(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
    send("rst_lw");
    check("rstw_we", {31'd0, IMem_WE}, 32'd1);
    RST = 1'b0;
    tick();
    check("rstw_we_off", {31'd0, IMem_WE}, 32'd0);
    check("rstw_addr",   IMem_Addr, 32'h0);
    check("rstw_wdata",  IMem_WData, 32'h0);
    check("rstw_count",  {25'd0, Count}, 32'd0);
    check("rstw_flags",  {28'd0, In_Ready, Done, Full, Err}, 32'd0);
    tick();
    check("rstw_one_we", wr_addr.size(), 32'd1);
    RST = 1'b1;
    tick();
    pulse_start();
    set_desc(3'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
    send("post_rst");
    check("post_rst_addr",  IMem_Addr, 32'h0);
    check("post_rst_wdata", IMem_WData, 32'h00500093);
    tick();
    check("post_rst_count", {25'd0, Count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
